// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage RISC-V pipeline-stage registers.
//   - stage_state_e : occupancy state of a pipe_skid_reg stage
//   - RV_NOP        : canonical NOP (addi x0, x0, 0) used as a bubble
//   - payload widths and field offsets for IF/ID, ID/EX, EX/MEM, MEM/WB
//   - ifid_pack     : helper to assemble an IF/ID payload
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Occupancy of a stage: nothing, main entry only, main + skid entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // IF/ID payload: {pc, instr, pc_4}
  localparam int IFID_PC4_LSB   = 0;
  localparam int IFID_INSTR_LSB = 32;
  localparam int IFID_PC_LSB    = 64;
  localparam int IFID_W         = 96;
  localparam logic [IFID_W-1:0] IFID_FLUSH_VAL = {32'h0, RV_NOP, 32'h0};

  // ID/EX payload: {pc, rs1_val, rs2_val, imm, rd, ctrl}
  localparam int IDEX_CTRL_W    = 16;
  localparam int IDEX_CTRL_LSB  = 0;
  localparam int IDEX_RD_LSB    = 16;
  localparam int IDEX_IMM_LSB   = 21;
  localparam int IDEX_RS2_LSB   = 53;
  localparam int IDEX_RS1_LSB   = 85;
  localparam int IDEX_PC_LSB    = 117;
  localparam int IDEX_W         = 149;

  // EX/MEM payload: {alu_res, rs2_val, rd, ctrl}
  localparam int EXMEM_CTRL_W   = 8;
  localparam int EXMEM_CTRL_LSB = 0;
  localparam int EXMEM_RD_LSB   = 8;
  localparam int EXMEM_RS2_LSB  = 13;
  localparam int EXMEM_ALU_LSB  = 45;
  localparam int EXMEM_W        = 77;

  // MEM/WB payload: {wb_data, rd, ctrl}
  localparam int MEMWB_CTRL_W   = 4;
  localparam int MEMWB_CTRL_LSB = 0;
  localparam int MEMWB_RD_LSB   = 4;
  localparam int MEMWB_WB_LSB   = 9;
  localparam int MEMWB_W        = 41;

  function automatic logic [IFID_W-1:0] ifid_pack(
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [31:0] pc_4
  );
    return {pc, instr, pc_4};
  endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear, wins over inc
//   inc        : count up by one when not saturated
//   cnt        : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = &r_cnt;
  assign cnt      = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Generic pipeline-stage register with a 2-entry skid buffer, hazard stall,
// flush-to-bubble and a saturating stall-cycle counter.
//
// Handshake: a payload moves across an interface on a rising edge where
// valid & ready are both high (the output side additionally requires
// stall = 0). A producer holds valid and data stable until it transfers;
// in_ready is decoded from the state register alone, so it never depends
// combinationally on out_ready or stall.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : upstream payload present
//   in_ready    : stage can accept (state != TWO)
//   in_data     : upstream payload
//   out_valid   : stage holds a payload (state != EMPTY)
//   out_ready   : downstream accepts
//   out_data    : main register (oldest held payload)
//   stall       : hazard hold, forces the output side to not transfer
//   flush       : drop everything held and incoming, load FLUSH_VAL
//   cnt_clr     : synchronous clear of stall_cnt
//   stall_cnt   : saturating count of cycles a held payload was blocked
//   dbg_state   : current occupancy state (stage_state_e encoding)
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = 96,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  stage_state_e      r_state;
  stage_state_e      w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_skid_nxt;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_cnt_inc;

  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = (r_state != ST_TWO);
  assign out_data  = r_main;
  assign dbg_state = r_state;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready & ~stall;

  // A held payload that could not leave this cycle; a flush cycle is not
  // counted because the payload is being discarded, not blocked.
  assign w_cnt_inc = out_valid & (stall | ~out_ready) & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Incoming payload in this cycle is discarded even if in_ready = 1.
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = FLUSH_VAL;
      w_skid_nxt  = FLUSH_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = in_data;
          end else if (w_out_xfer) begin
            // main keeps its last value while the stage is empty
            w_state_nxt = ST_EMPTY;
          end else if (w_in_xfer) begin
            w_skid_nxt  = in_data;
            w_state_nxt = ST_TWO;
          end
        end
        ST_TWO: begin
          if (w_out_xfer) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= FLUSH_VAL;
      r_skid  <= FLUSH_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (w_cnt_inc),
    .cnt   (stall_cnt)
  );

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Generic, parametrised pipeline-stage register that replaces the fixed IF/ID-style registers between any two stages of the 5-stage RISC-V pipeline.
- Carries an opaque DATA_W payload with a valid/ready handshake and a 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.
- Supports hazard-unit stall and flush. On flush, the stage loads a parametrised bubble pattern (e.g. NOP) instead of zero.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 96: payload width. For IF/ID this is {pc, instr, pc_4}.
- FLUSH_VAL, 96'h0: value loaded into the output register on reset and flush. The IF/ID instance uses NOP 32'h00000013 in the instr field.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream has a payload.
- in_ready, output, 1: stage can accept a payload.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: stage presents a payload.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_W: payload to the downstream stage.
- stall, input, 1: hazard hold. While high, out_ready is treated as 0.
- flush, input, 1: discard all held and incoming payloads.
- cnt_clr, input, 1: synchronous clear of stall_cnt.
- stall_cnt, output, CNT_W: saturating count of blocked cycles.

Behaviour:
- Transfer definitions:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready & ~stall.
- State register has three states: EMPTY, ONE (main entry valid), TWO (main and skid entries valid).
- Reset (rst_n=0, asynchronous):
  - state = EMPTY; main = FLUSH_VAL; skid = FLUSH_VAL.
  - out_valid = 0, in_ready = 1, stall_cnt = 0.
- Output decode:
  - out_valid = (state != EMPTY).
  - out_data = main register.
  - in_ready = (state != TWO). It decodes from the state register only; there is no combinational path from out_ready or stall.
- Transitions when flush = 0:
  - EMPTY:
    - in_xfer: main <= in_data, go to ONE.
    - Otherwise: hold.
  - ONE:
    - in_xfer & out_xfer: main <= in_data, stay in ONE.
    - out_xfer only: go to EMPTY; main retains its last value.
    - in_xfer only: skid <= in_data, go to TWO.
  - TWO:
    - out_xfer: main <= skid, go to ONE.
    - Otherwise: hold. in_xfer is impossible because in_ready = 0.
- Latency: one cycle from in_xfer in the EMPTY state to out_valid. Sustained throughput is one transfer per cycle.
- Flush (synchronous, highest priority, overrides stall and out_ready):
  - Next state = EMPTY; main <= FLUSH_VAL; the skid entry is dropped.
  - A payload presented in the flush cycle is discarded even if in_ready = 1.
  - Any out_xfer in that cycle still counts downstream.
  - in_ready = 1 in the following cycle.
- Stall: blocks only the output side. Input still fills the skid, so the stage holds up to 2 payloads before in_ready drops.
- stall_cnt:
  - Increments when out_valid & (stall | ~out_ready) & ~flush.
  - Saturates at all-ones and never wraps.
  - cnt_clr has priority over increment.
  - Unaffected by flush.
- Payload ordering is strictly FIFO. No payload is duplicated or lost except by flush.
- Reset asserted mid-operation: all state is lost immediately. There is no handshake with neighbours.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum (EMPTY/ONE/TWO);
  - the RV NOP constant 32'h00000013;
  - IF/ID, ID/EX, EX/MEM and MEM/WB payload width constants and field offsets.
- Sub-module sat_counter (CNT_W-wide, with clr and inc inputs) is used for stall_cnt.
- The stage datapath stays in the top module.

Test Plan:
- Reset, then in_valid=1 with data 0x11 and out_ready=1 → out_valid=1 with out_data=0x11 exactly one cycle later. Streaming 0x11..0x15 emerges back-to-back with no gaps.
- out_ready=0 while streaming 0xA1, 0xA2, 0xA3 → in_ready falls after 0xA2 is accepted and 0xA3 is held upstream. Releasing out_ready yields 0xA1, 0xA2, 0xA3 in order.
- stall=1 for 3 cycles with out_ready=1 while in state ONE → out_data is held and stall_cnt=3. Then cnt_clr → stall_cnt=0.
- State TWO, assert flush together with in_valid (0xBB) and stall → next cycle out_valid=0, out_data=FLUSH_VAL, in_ready=1, and 0xBB never appears.
- CNT_W=4 with a 20-cycle stall → stall_cnt saturates at 15 and does not wrap.
- rst_n pulsed low mid-cycle while in state TWO → outputs return to reset values immediately, before the next clk edge.
